// File: rtl/disk_flip_sequencer.sv
// disk_flip_sequencer
// Walks the board RAM outward from a freshly placed disk in all eight
// directions, rewrites every bracketed run of opponent disks to the mover's
// colour, and finally rewrites the placed cell itself when anything flipped.
//
// Optional feature macro: FLIP_DRAW_EN
//   defined   - each board write is followed by a single-cell redraw request
//               (draw_req/draw_ack handshake, draw_x/draw_y hold the cell).
//   undefined - no redraw traffic: draw_req/draw_x/draw_y are tied to 0,
//               draw_ack is ignored and flips of one run go out on
//               consecutive cycles; the caller redraws the board after done.
module disk_flip_sequencer #(
    parameter int BOARD_BITS = 3,
    parameter int CELL_W     = 2
) (
    input  logic                  clk,
    input  logic                  restart,
    input  logic                  start,
    input  logic [BOARD_BITS-1:0] pos_x,
    input  logic [BOARD_BITS-1:0] pos_y,
    input  logic                  side,
    output logic [BOARD_BITS-1:0] rd_x,
    output logic [BOARD_BITS-1:0] rd_y,
    input  logic [CELL_W-1:0]     rd_data,
    output logic                  wr_en,
    output logic [BOARD_BITS-1:0] wr_x,
    output logic [BOARD_BITS-1:0] wr_y,
    output logic [CELL_W-1:0]     wr_data,
    output logic                  draw_req,
    input  logic                  draw_ack,
    output logic [BOARD_BITS-1:0] draw_x,
    output logic [BOARD_BITS-1:0] draw_y,
    output logic                  busy,
    output logic                  done,
    output logic [5:0]            flip_count
);

    // Cursor arithmetic carries one extra sign bit so that stepping off either
    // edge of the board (to -1 or to 2^BOARD_BITS) shows up as MSB set.
    localparam int CW    = BOARD_BITS + 1;
    localparam int RUN_W = BOARD_BITS;

    localparam logic [CELL_W-1:0] CELL_BLACK = CELL_W'(1);
    localparam logic [CELL_W-1:0] CELL_WHITE = CELL_W'(2);

    typedef enum logic [3:0] {
        IDLE,
        DIR_INIT,
        READ,
        EVAL,
        FLIP,
        DRAW_WAIT,
        NEXT_DIR,
        ORIGIN,
        FINISH
    } state_t;

    state_t                state_q;
    logic [BOARD_BITS-1:0] pos_x_q;
    logic [BOARD_BITS-1:0] pos_y_q;
    logic [CELL_W-1:0]     own_q;
    logic [CELL_W-1:0]     opp_q;
    logic [2:0]            dir_q;
    logic signed [CW-1:0]  cur_x_q;
    logic signed [CW-1:0]  cur_y_q;
    logic [RUN_W-1:0]      run_q;
    logic [5:0]            flip_count_q;
    logic [BOARD_BITS-1:0] rd_x_q;
    logic [BOARD_BITS-1:0] rd_y_q;
    logic                  wr_en_q;
    logic [BOARD_BITS-1:0] wr_x_q;
    logic [BOARD_BITS-1:0] wr_y_q;
    logic [CELL_W-1:0]     wr_data_q;
    logic                  busy_q;
    logic                  done_q;

    // Direction table, index 0..7 = N, NE, E, SE, S, SW, W, NW.
    // x grows to the east (column), y grows to the south (row).
    logic signed [CW-1:0] dx_tab [8];
    logic signed [CW-1:0] dy_tab [8];

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_dir
            localparam int DX = (gi >= 1 && gi <= 3) ? 1 : ((gi >= 5) ? -1 : 0);
            localparam int DY = (gi <= 1 || gi == 7) ? -1 : ((gi >= 3 && gi <= 5) ? 1 : 0);
            assign dx_tab[gi] = CW'(DX);
            assign dy_tab[gi] = CW'(DY);
        end
    endgenerate

    logic signed [CW-1:0] dx;
    logic signed [CW-1:0] dy;
    logic signed [CW-1:0] org_x;
    logic signed [CW-1:0] org_y;
    logic signed [CW-1:0] init_x;
    logic signed [CW-1:0] init_y;
    logic signed [CW-1:0] fwd_x;
    logic signed [CW-1:0] fwd_y;
    logic signed [CW-1:0] back_x;
    logic signed [CW-1:0] back_y;
    logic                 off_init;
    logic                 off_fwd;
    logic                 rd_is_opp;
    logic                 rd_is_own;
    logic                 run_nz;
    logic                 run_more;

    assign dx     = dx_tab[dir_q];
    assign dy     = dy_tab[dir_q];
    assign org_x  = $signed({1'b0, pos_x_q});
    assign org_y  = $signed({1'b0, pos_y_q});
    assign init_x = org_x + dx;
    assign init_y = org_y + dy;
    assign fwd_x  = cur_x_q + dx;
    assign fwd_y  = cur_y_q + dy;
    assign back_x = cur_x_q - dx;
    assign back_y = cur_y_q - dy;

    assign off_init  = init_x[CW-1] | init_y[CW-1];
    assign off_fwd   = fwd_x[CW-1] | fwd_y[CW-1];
    // Reserved code 11 matches neither own nor opponent, so it ends a run like empty.
    assign rd_is_opp = (rd_data == opp_q);
    assign rd_is_own = (rd_data == own_q);
    assign run_nz    = (run_q != '0);
    // Another cell remains in the run after the one being flipped now.
    assign run_more  = (run_q > RUN_W'(1));

`ifdef FLIP_DRAW_EN
    logic                  draw_req_q;
    logic [BOARD_BITS-1:0] draw_x_q;
    logic [BOARD_BITS-1:0] draw_y_q;
    logic                  origin_q;   // current redraw is the placed cell itself
`endif

    // Sequencer FSM: board walk, flip writes, redraw handshake, completion.
    always_ff @(posedge clk) begin
        if (restart) begin
            state_q      <= IDLE;
            pos_x_q      <= '0;
            pos_y_q      <= '0;
            own_q        <= '0;
            opp_q        <= '0;
            dir_q        <= '0;
            cur_x_q      <= '0;
            cur_y_q      <= '0;
            run_q        <= '0;
            flip_count_q <= '0;
            rd_x_q       <= '0;
            rd_y_q       <= '0;
            wr_en_q      <= 1'b0;
            wr_x_q       <= '0;
            wr_y_q       <= '0;
            wr_data_q    <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
`ifdef FLIP_DRAW_EN
            draw_req_q   <= 1'b0;
            draw_x_q     <= '0;
            draw_y_q     <= '0;
            origin_q     <= 1'b0;
`endif
        end else begin
            wr_en_q <= 1'b0;
            done_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        pos_x_q      <= pos_x;
                        pos_y_q      <= pos_y;
                        own_q        <= side ? CELL_WHITE : CELL_BLACK;
                        opp_q        <= side ? CELL_BLACK : CELL_WHITE;
                        flip_count_q <= '0;
                        dir_q        <= '0;
                        busy_q       <= 1'b1;
`ifdef FLIP_DRAW_EN
                        origin_q     <= 1'b0;
`endif
                        state_q      <= DIR_INIT;
                    end
                end

                DIR_INIT: begin
                    cur_x_q <= init_x;
                    cur_y_q <= init_y;
                    run_q   <= '0;
                    if (off_init) begin
                        state_q <= NEXT_DIR;
                    end else begin
                        // Address goes out during READ so data lands in EVAL.
                        rd_x_q  <= init_x[BOARD_BITS-1:0];
                        rd_y_q  <= init_y[BOARD_BITS-1:0];
                        state_q <= READ;
                    end
                end

                READ: begin
                    state_q <= EVAL;
                end

                EVAL: begin
                    if (rd_is_opp) begin
                        run_q   <= run_q + RUN_W'(1);
                        cur_x_q <= fwd_x;
                        cur_y_q <= fwd_y;
                        if (off_fwd) begin
                            state_q <= NEXT_DIR;
                        end else begin
                            rd_x_q  <= fwd_x[BOARD_BITS-1:0];
                            rd_y_q  <= fwd_y[BOARD_BITS-1:0];
                            state_q <= READ;
                        end
                    end else if (rd_is_own && run_nz) begin
                        // Bracket closed: step back onto the last opponent disk.
                        cur_x_q <= back_x;
                        cur_y_q <= back_y;
                        state_q <= FLIP;
                    end else begin
                        state_q <= NEXT_DIR;
                    end
                end

                FLIP: begin
                    wr_en_q      <= 1'b1;
                    wr_x_q       <= cur_x_q[BOARD_BITS-1:0];
                    wr_y_q       <= cur_y_q[BOARD_BITS-1:0];
                    wr_data_q    <= own_q;
                    flip_count_q <= flip_count_q + 6'd1;
`ifdef FLIP_DRAW_EN
                    draw_x_q     <= cur_x_q[BOARD_BITS-1:0];
                    draw_y_q     <= cur_y_q[BOARD_BITS-1:0];
                    state_q      <= DRAW_WAIT;
`else
                    run_q        <= run_q - RUN_W'(1);
                    if (run_more) begin
                        cur_x_q <= back_x;
                        cur_y_q <= back_y;
                        state_q <= FLIP;
                    end else begin
                        state_q <= NEXT_DIR;
                    end
`endif
                end

`ifdef FLIP_DRAW_EN
                DRAW_WAIT: begin
                    // First cycle here carries the write strobe; the request
                    // rises one cycle later and is held until acknowledged.
                    if (draw_req_q && draw_ack) begin
                        draw_req_q <= 1'b0;
                        if (origin_q) begin
                            state_q <= FINISH;
                        end else begin
                            run_q <= run_q - RUN_W'(1);
                            if (run_more) begin
                                cur_x_q <= back_x;
                                cur_y_q <= back_y;
                                state_q <= FLIP;
                            end else begin
                                state_q <= NEXT_DIR;
                            end
                        end
                    end else begin
                        draw_req_q <= 1'b1;
                    end
                end
`else
                DRAW_WAIT: begin
                    state_q <= NEXT_DIR;
                end
`endif

                NEXT_DIR: begin
                    if (dir_q == 3'd7) begin
                        state_q <= ORIGIN;
                    end else begin
                        dir_q   <= dir_q + 3'd1;
                        state_q <= DIR_INIT;
                    end
                end

                ORIGIN: begin
                    // The placed disk is only committed when the move flipped something.
                    if (flip_count_q != 6'd0) begin
                        wr_en_q   <= 1'b1;
                        wr_x_q    <= pos_x_q;
                        wr_y_q    <= pos_y_q;
                        wr_data_q <= own_q;
`ifdef FLIP_DRAW_EN
                        draw_x_q  <= pos_x_q;
                        draw_y_q  <= pos_y_q;
                        origin_q  <= 1'b1;
                        state_q   <= DRAW_WAIT;
`else
                        state_q   <= FINISH;
`endif
                    end else begin
                        state_q <= FINISH;
                    end
                end

                FINISH: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign rd_x       = rd_x_q;
    assign rd_y       = rd_y_q;
    assign wr_en      = wr_en_q;
    assign wr_x       = wr_x_q;
    assign wr_y       = wr_y_q;
    assign wr_data    = wr_data_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign flip_count = flip_count_q;

`ifdef FLIP_DRAW_EN
    assign draw_req = draw_req_q;
    assign draw_x   = draw_x_q;
    assign draw_y   = draw_y_q;
`else
    logic unused_draw_ack;
    assign unused_draw_ack = draw_ack;
    assign draw_req        = 1'b0;
    assign draw_x          = '0;
    assign draw_y          = '0;
`endif

endmodule

// File: tb/tb_disk_flip_sequencer.sv
// Bench for disk_flip_sequencer: behavioural board RAM with one-cycle read
// latency, redraw acknowledger with programmable delay, write/draw/done
// monitor, a table of directed moves, and hand sequences for busy-start,
// restart and (when FLIP_DRAW_EN is defined) the redraw stall.
module tb_disk_flip_sequencer;

`ifdef FLIP_DRAW_EN
    localparam int DRAW_ON = 1;
`else
    localparam int DRAW_ON = 0;
`endif

    logic       clk = 1'b0;
    logic       restart = 1'b1;
    logic       start = 1'b0;
    logic [2:0] pos_x = '0;
    logic [2:0] pos_y = '0;
    logic       side = 1'b0;
    logic [2:0] rd_x, rd_y;
    logic [1:0] rd_data;
    logic       wr_en;
    logic [2:0] wr_x, wr_y;
    logic [1:0] wr_data;
    logic       draw_req;
    logic       draw_ack;
    logic [2:0] draw_x, draw_y;
    logic       busy, done;
    logic [5:0] flip_count;

    disk_flip_sequencer dut (
        .clk(clk), .restart(restart), .start(start),
        .pos_x(pos_x), .pos_y(pos_y), .side(side),
        .rd_x(rd_x), .rd_y(rd_y), .rd_data(rd_data),
        .wr_en(wr_en), .wr_x(wr_x), .wr_y(wr_y), .wr_data(wr_data),
        .draw_req(draw_req), .draw_ack(draw_ack),
        .draw_x(draw_x), .draw_y(draw_y),
        .busy(busy), .done(done), .flip_count(flip_count)
    );

    always #5 clk = ~clk;

    // Board RAM model, indexed [y][x]; load_en replaces contents with a preset.
    logic [1:0] board [8][8];
    int         board_sel = 0;
    logic       load_en = 1'b0;

    always @(posedge clk) begin
        if (load_en) begin
            for (int y = 0; y < 8; y++)
                for (int x = 0; x < 8; x++)
                    board[y][x] <= 2'b00;
            case (board_sel)
                0: begin
                    board[3][3] <= 2'b10; board[4][4] <= 2'b10;
                    board[4][3] <= 2'b01; board[3][4] <= 2'b01;
                end
                1: begin
                    for (int x = 1; x < 8; x++) board[0][x] <= 2'b10;
                end
                default: begin
                    board[0][4] <= 2'b01; board[4][0] <= 2'b01; board[0][0] <= 2'b01;
                    board[1][1] <= 2'b10; board[2][2] <= 2'b10; board[3][3] <= 2'b10;
                    board[4][1] <= 2'b10; board[4][2] <= 2'b10; board[4][3] <= 2'b10;
                end
            endcase
        end else if (wr_en) begin
            board[wr_y][wr_x] <= wr_data;
        end
        rd_data <= board[rd_y][rd_x];
    end

    // Redraw acknowledger: ack after draw_req has been high ack_delay cycles.
    int ack_delay = 0;
    int ack_cnt = 0;
    assign draw_ack = draw_req && (ack_cnt >= ack_delay);

    always @(posedge clk) begin
        if (!draw_req)     ack_cnt <= 0;
        else if (!draw_ack) ack_cnt <= ack_cnt + 1;
    end

    // Monitor of DUT activity, sampled on the falling edge.
    logic       mon_clr = 1'b1;
    logic [5:0] wr_log_xy [32];
    logic [1:0] wr_log_d  [32];
    int         wr_n = 0;
    int         draw_cycles = 0;
    int         done_cnt = 0;

    always @(negedge clk) begin
        if (mon_clr) begin
            wr_n        <= 0;
            draw_cycles <= 0;
            done_cnt    <= 0;
        end else begin
            if (wr_en && wr_n < 32) begin
                wr_log_xy[wr_n] <= {wr_x, wr_y};
                wr_log_d[wr_n]  <= wr_data;
                wr_n            <= wr_n + 1;
            end
            if (draw_req) draw_cycles <= draw_cycles + 1;
            if (done)     done_cnt    <= done_cnt + 1;
        end
    end

    logic [29:0] outs_bus;
    assign outs_bus = {rd_x, rd_y, wr_en, wr_x, wr_y, wr_data, draw_req,
                       draw_x, draw_y, busy, done, flip_count};

    int n_checks = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [5:0] xy(input int x, input int y);
        return {3'(x), 3'(y)};
    endfunction

    typedef struct {
        logic [2:0]  px;
        logic [2:0]  py;
        logic        side;
        int          bsel;
        int          exp_flips;
        int          exp_nwr;
        logic [47:0] exp_wr;   // write k at bits [6k +: 6] as {x,y}
    } vec_t;

    function automatic vec_t mk(input int px, input int py, input int sd, input int bsel,
                                input int flips, input int nwr, input logic [47:0] wr);
        vec_t v;
        v.px = 3'(px); v.py = 3'(py); v.side = sd[0]; v.bsel = bsel;
        v.exp_flips = flips; v.exp_nwr = nwr; v.exp_wr = wr;
        return v;
    endfunction

    task automatic load_and_start(input int bsel, input int px, input int py, input logic sd);
        @(posedge clk); #1;
        board_sel = bsel; load_en = 1'b1; mon_clr = 1'b1;
        @(posedge clk); #1;
        load_en = 1'b0; mon_clr = 1'b0;
        pos_x = 3'(px); pos_y = 3'(py); side = sd; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(output bit got);
        got = 1'b0;
        for (int c = 0; c < 4000 && !got; c++) begin
            @(negedge clk);
            if (done) got = 1'b1;
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        bit got;
        logic [1:0] own;
        own = v.side ? 2'b10 : 2'b01;
        load_and_start(v.bsel, v.px, v.py, v.side);
        @(negedge clk);
        check($sformatf("v%0d_busy_after_start", idx), busy, 1);
        wait_done(got);
        check($sformatf("v%0d_done_seen", idx), got, 1);
        check($sformatf("v%0d_busy_at_done", idx), busy, 0);
        @(negedge clk);
        @(negedge clk);
        check($sformatf("v%0d_flip_count", idx), flip_count, v.exp_flips);
        check($sformatf("v%0d_done_pulses", idx), done_cnt, 1);
        check($sformatf("v%0d_write_count", idx), wr_n, v.exp_nwr);
        check($sformatf("v%0d_draw_cycles", idx), draw_cycles, DRAW_ON ? v.exp_nwr : 0);
        for (int k = 0; k < v.exp_nwr && k < 8; k++) begin
            check($sformatf("v%0d_write%0d_xy", idx, k), wr_log_xy[k], v.exp_wr[6*k +: 6]);
            check($sformatf("v%0d_write%0d_data", idx, k), wr_log_d[k], own);
        end
        $display("vec %0d: pos=(%0d,%0d) side=%0d flips=%0d writes=%0d draws=%0d",
                 idx, v.px, v.py, v.side, flip_count, wr_n, draw_cycles);
    endtask

    vec_t vecs [5];

    initial begin
        bit got;

        vecs[0] = mk(2, 3, 0, 0, 1, 2, {36'd0, xy(2,3), xy(3,3)});
        vecs[1] = mk(0, 0, 0, 0, 0, 0, 48'd0);
        vecs[2] = mk(0, 0, 0, 1, 0, 0, 48'd0);
        // Board 2 also holds black at (0,0) so the NW diagonal is bracketed.
        vecs[3] = mk(4, 4, 0, 2, 6, 7, {6'd0, xy(4,4), xy(3,3), xy(2,2), xy(1,1),
                                        xy(3,4), xy(2,4), xy(1,4)});
        vecs[4] = mk(4, 2, 1, 0, 1, 2, {36'd0, xy(4,2), xy(4,3)});

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", {2'b00, outs_bus}, 32'd0);
        @(posedge clk); #1;
        restart = 1'b0;

        for (int i = 0; i < 5; i++) run_vec(i, vecs[i]);

        // Start pulsed while busy must be ignored.
        load_and_start(0, 2, 3, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        pos_x = 3'd0; pos_y = 3'd0; side = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(got);
        check("busy_start_done_seen", got, 1);
        @(negedge clk);
        check("busy_start_flip_count", flip_count, 1);
        check("busy_start_write_count", wr_n, 2);
        check("busy_start_first_write", wr_log_xy[0], xy(3,3));
        check("busy_start_write_data", wr_log_d[0], 2'b01);
        check("busy_start_done_pulses", done_cnt, 1);
        $display("busy-start: flips=%0d writes=%0d", flip_count, wr_n);

        // Restart in the middle of the multi-direction move.
        load_and_start(2, 4, 4, 1'b0);
        got = 1'b0;
        for (int c = 0; c < 2000 && !got; c++) begin
            @(negedge clk);
            if (wr_en) got = 1'b1;
        end
        check("restart_first_write_seen", got, 1);
        @(posedge clk); #1;
        restart = 1'b1;
        @(posedge clk); #1;
        restart = 1'b0;
        @(negedge clk);
        check("restart_outputs_zero", {2'b00, outs_bus}, 32'd0);
        repeat (100) @(negedge clk);
        check("restart_no_done", done_cnt, 0);
        check("restart_idle_busy", busy, 0);
        $display("restart: writes before abort=%0d done pulses=%0d", wr_n, done_cnt);

        // Recovery after restart.
        run_vec(5, vecs[0]);

`ifdef FLIP_DRAW_EN
        // Redraw stall: request held three cycles on the flipped cell.
        ack_delay = 2;
        load_and_start(0, 2, 3, 1'b0);
        got = 1'b0;
        for (int c = 0; c < 2000 && !got; c++) begin
            @(negedge clk);
            if (wr_en) got = 1'b1;
        end
        check("stall_write_seen", got, 1);
        check("stall_req_after_write", draw_req, 0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("stall_req_c%0d", k), draw_req, 1);
            check($sformatf("stall_xy_c%0d", k), {draw_x, draw_y}, xy(3,3));
            check($sformatf("stall_no_wr_c%0d", k), wr_en, 0);
        end
        @(negedge clk);
        check("stall_req_dropped", draw_req, 0);
        wait_done(got);
        check("stall_done_seen", got, 1);
        check("stall_flip_count", flip_count, 1);
        ack_delay = 0;
        $display("stall: flips=%0d", flip_count);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
